// File: rtl/adbg_wb_burst_ctrl_if.sv
// Bundle of command, write/read stream, status and BIU handshake signals for the burst engine.
// The slave modport is the burst engine; master is the host/BIU side that drives it.
interface adbg_wb_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_word_size;
  logic [CNT_WIDTH-1:0]  cmd_count;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  logic                  busy;
  logic                  done;
  logic                  err_flag;
  logic [ADDR_WIDTH-1:0] err_addr;

  logic [DATA_WIDTH-1:0] biu_di;
  logic [DATA_WIDTH-1:0] biu_do;
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic                  biu_strb;
  logic                  biu_rw;
  logic [3:0]            biu_word_size;
  logic                  biu_rdy;
  logic                  biu_err;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_word_size, cmd_count,
    input  wr_data, wr_valid, rd_ready,
    input  biu_do, biu_rdy, biu_err,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output busy, done, err_flag, err_addr,
    output biu_di, biu_addr, biu_strb, biu_rw, biu_word_size
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_word_size, cmd_count,
    output wr_data, wr_valid, rd_ready,
    output biu_do, biu_rdy, biu_err,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  busy, done, err_flag, err_addr,
    input  biu_di, biu_addr, biu_strb, biu_rw, biu_word_size
  );
endinterface

// File: rtl/adbg_wb_burst_ctrl.sv
// TCK-domain burst engine: splits a burst command into single BIU accesses with
// address auto-increment, streams read data out and records the first bus error.
module adbg_wb_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 biu_clk,
  input  logic                 biu_rst,
  adbg_wb_burst_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_WD = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RD_OUT = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            size_q, size_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  strb_q, strb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // State and all output/data registers
  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      count_q     <= '0;
      rw_q        <= 1'b0;
      di_q        <= '0;
      rd_data_q   <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      strb_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      count_q     <= count_d;
      rw_q        <= rw_d;
      di_q        <= di_d;
      rd_data_q   <= rd_data_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      strb_q      <= strb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    count_d    = count_q;
    rw_d       = rw_q;
    di_d       = di_q;
    rd_data_d  = rd_data_q;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d     = bus.cmd_addr;
          count_d    = bus.cmd_count;
          rw_d       = ~bus.cmd_write;
          err_flag_d = 1'b0;
          err_addr_d = '0;
          unique case (bus.cmd_word_size)
            4'd1:    size_d = 4'd1;
            4'd2:    size_d = 4'd2;
            default: size_d = 4'd4;
          endcase
          if (bus.cmd_count == '0)  state_d = FINISH;
          else if (bus.cmd_write)   state_d = GET_WD;
          else                      state_d = ISSUE;
        end
      end
      GET_WD: begin
        if (bus.wr_valid) begin
          unique case (size_q)
            4'd1:    di_d = {bus.wr_data[7:0],  {(DATA_WIDTH-8){1'b0}}};
            4'd2:    di_d = {bus.wr_data[15:0], {(DATA_WIDTH-16){1'b0}}};
            default: di_d = bus.wr_data;
          endcase
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.biu_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (bus.biu_rdy) begin
          if (bus.biu_err && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = addr_q;
          end
          addr_d  = addr_q + ADDR_WIDTH'(size_q);
          count_d = count_q - CNT_WIDTH'(1);
          if (rw_q) begin
            unique case (size_q)
              4'd1:    rd_data_d = {{(DATA_WIDTH-8){1'b0}},  bus.biu_do[7:0]};
              4'd2:    rd_data_d = {{(DATA_WIDTH-16){1'b0}}, bus.biu_do[15:0]};
              default: rd_data_d = bus.biu_do;
            endcase
            state_d = RD_OUT;
          end else if (count_q == CNT_WIDTH'(1)) begin
            state_d = FINISH;
          end else begin
            state_d = GET_WD;
          end
        end
      end
      RD_OUT: begin
        if (bus.rd_ready) state_d = (count_q == '0) ? FINISH : ISSUE;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake/status outputs are registered decodes of the next state
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == GET_WD);
    strb_d      = (state_d == ISSUE);
    rd_valid_d  = (state_d == RD_OUT);
    done_d      = (state_d == FINISH);
    busy_d      = (state_d == GET_WD) || (state_d == ISSUE) ||
                  (state_d == WAIT)   || (state_d == RD_OUT);
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.wr_ready      = wr_ready_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_flag      = err_flag_q;
  assign bus.err_addr      = err_addr_q;
  assign bus.biu_di        = di_q;
  assign bus.biu_addr      = addr_q;
  assign bus.biu_strb      = strb_q;
  assign bus.biu_rw        = rw_q;
  assign bus.biu_word_size = size_q;

endmodule
